ama_riscv_lsu_ctrl: RTL and testbench

AMA_RISCV_LSU_CTRL -- requirements
Module: ama_riscv_lsu_ctrl

---
 rtl/ama_riscv_lsu_ctrl_if.sv | 41 ++++
 rtl/ama_riscv_lsu_ctrl.sv | 149 ++++++++++++++
 tb/tb_ama_riscv_lsu_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ama_riscv_lsu_ctrl_if.sv
// Core-side request, DMEM and shift/mask-unit signals of the load/store controller.
// The controller uses the slave view and the core/memory environment uses the master view.
interface ama_riscv_lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [31:0] req_addr;
  logic [2:0]  req_width;
  logic [31:0] req_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        lsm_en;
  logic [1:0]  lsm_offset;
  logic [2:0]  lsm_width;
  logic [31:0] lsm_data;
  logic        done;
  logic        err_misaligned;
  logic        err_timeout;
  logic        busy;

  modport slave (
    input  req_valid, req_store, req_addr, req_width, req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, mem_req_valid, mem_addr, mem_we, mem_wdata,
    output lsm_en, lsm_offset, lsm_width, lsm_data,
    output done, err_misaligned, err_timeout, busy
  );

  modport master (
    output req_valid, req_store, req_addr, req_width, req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, mem_req_valid, mem_addr, mem_we, mem_wdata,
    input  lsm_en, lsm_offset, lsm_width, lsm_data,
    input  done, err_misaligned, err_timeout, busy
  );
endinterface

// File: rtl/ama_riscv_lsu_ctrl.sv
// Load/store controller: accepts one core request at a time, runs the DMEM handshake,
// and hands load words to the shift/mask unit, with misalignment and timeout faults.
module ama_riscv_lsu_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  ama_riscv_lsu_ctrl_if.slave        bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic [7:0]  cnt_r;
  logic        store_r;
  logic [31:0] addr_r;
  logic [2:0]  width_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic [31:0] lsm_data_r;
  logic        timeout_r;
  logic        accept_s;
  logic        misaligned_s;
  logic        expire_s;
  logic        to_err_s;

  function automatic logic is_misaligned(input logic [2:0] width, input logic [1:0] off);
    case (width[1:0])
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = (off != 2'd0);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] width, input logic [1:0] off);
    case (width[1:0])
      2'd0:    byte_en = 4'b0001 << off;
      2'd1:    byte_en = 4'b0011 << off;
      2'd2:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] width, input logic [31:0] wdata);
    case (width[1:0])
      2'd0:    lane_data = {4{wdata[7:0]}};
      2'd1:    lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

  assign accept_s     = bus.req_valid && (state_r == ST_IDLE);
  assign misaligned_s = is_misaligned(bus.req_width, bus.req_addr[1:0]);
  assign expire_s     = (cnt_r == CNT_LAST);

  // Next-state decode; a handshake in the last allowed cycle beats the timeout.
  always_comb begin
    state_nxt_s = state_r;
    to_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = misaligned_s ? ST_ERR : ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) begin
          state_nxt_s = store_r ? ST_DONE : ST_WAIT;
        end else if (expire_s) begin
          state_nxt_s = ST_ERR;
          to_err_s    = 1'b1;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rsp_valid) begin
          state_nxt_s = ST_DONE;
        end else if (expire_s) begin
          state_nxt_s = ST_ERR;
          to_err_s    = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      ST_ERR:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, latched request fields, timeout counter and captured load word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 8'd0;
      store_r    <= 1'b0;
      addr_r     <= 32'd0;
      width_r    <= 3'd0;
      be_r       <= 4'd0;
      wdata_r    <= 32'd0;
      lsm_data_r <= 32'd0;
      timeout_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        store_r   <= bus.req_store;
        addr_r    <= bus.req_addr;
        width_r   <= bus.req_width;
        be_r      <= bus.req_store ? byte_en(bus.req_width, bus.req_addr[1:0]) : 4'd0;
        wdata_r   <= lane_data(bus.req_width, bus.req_wdata);
        cnt_r     <= 8'd0;
        timeout_r <= 1'b0;
      end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
        cnt_r     <= cnt_r + 8'd1;
        timeout_r <= timeout_r | to_err_s;
      end
      if ((state_r == ST_WAIT) && bus.mem_rsp_valid) begin
        lsm_data_r <= bus.mem_rsp_data;
      end
    end
  end

  // Every output is a decode of the state register or a latched field.
  assign bus.req_ready      = (state_r == ST_IDLE);
  assign bus.mem_req_valid  = (state_r == ST_REQ);
  assign bus.mem_addr       = {addr_r[31:2], 2'b00};
  assign bus.mem_we         = (state_r == ST_REQ) ? be_r : 4'd0;
  assign bus.mem_wdata      = wdata_r;
  assign bus.lsm_en         = (state_r == ST_DONE) && !store_r;
  assign bus.lsm_offset     = addr_r[1:0];
  assign bus.lsm_width      = width_r;
  assign bus.lsm_data       = lsm_data_r;
  assign bus.done           = (state_r == ST_DONE) || (state_r == ST_ERR);
  assign bus.err_misaligned = (state_r == ST_ERR) && !timeout_r;
  assign bus.err_timeout    = (state_r == ST_ERR) && timeout_r;
  assign bus.busy           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_ama_riscv_lsu_ctrl.sv
// Directed bench for ama_riscv_lsu_ctrl: a transaction-level model predicts DMEM traffic,
// completion latency and fault flags; a negedge monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_ama_riscv_lsu_ctrl;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ama_riscv_lsu_ctrl_if bus ();
  ama_riscv_lsu_ctrl #(.TIMEOUT_CYC(T)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        store;
    logic        mis;
    logic        to;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [1:0]  off;
    logic [2:0]  width;
    logic [31:0] rdata;
    int          lat;
    int          mreq;
  } exp_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        cur;
  logic        active = 1'b0;
  logic        done_seen;
  int          acc_cyc, done_cyc, seen_lat, mreq_cnt;
  logic [31:0] seen_addr, seen_wdata, seen_lsm_data;
  logic [3:0]  seen_we;
  logic        seen_lsm_en, seen_err_m, seen_err_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What the spec says a request must produce, given how long memory stalls.
  function automatic exp_t model(input logic st, input logic [31:0] a, input logic [2:0] w,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input int rdy_wait, input int rsp_wait);
    exp_t e;
    int   off, nbytes, need;
    off     = int'(a[1:0]);
    nbytes  = (w[1:0] == 2'd3) ? 0 : (1 << w[1:0]);
    e.store = st;
    e.off   = a[1:0];
    e.width = w;
    e.rdata = rd;
    e.addr  = a - 32'(off);
    e.mis   = (nbytes == 0) || ((off % nbytes) != 0);
    e.we    = 4'd0;
    e.wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (st && (i >= off) && (i < off + nbytes)) e.we[i] = 1'b1;
      if (nbytes != 0) e.wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
    end
    need  = rdy_wait + 1 + (st ? 0 : rsp_wait + 1);
    e.to  = !e.mis && (need > T);
    e.lat = e.mis ? 1 : (e.to ? T + 1 : need + 1);
    e.mreq = e.mis ? 0 : ((rdy_wait + 1 < T) ? rdy_wait + 1 : T);
    return e;
  endfunction

  // Per-cycle comparison against the current expected transaction.
  initial begin
    forever begin
      @(negedge clk);
      if (active) begin
        chk("ready_vs_busy", bus.req_ready, !bus.busy);
        if (bus.mem_req_valid) begin
          mreq_cnt++;
          chk("mreq_when_misaligned", cur.mis, 1'b0);
          chk("mem_addr", bus.mem_addr, cur.addr);
          chk("mem_we", bus.mem_we, cur.we);
          if (cur.store) chk("mem_wdata", bus.mem_wdata, cur.wdata);
          chk("mreq_done_overlap", bus.done, 1'b0);
          seen_addr  = bus.mem_addr;
          seen_we    = bus.mem_we;
          seen_wdata = bus.mem_wdata;
        end
        if (bus.done && !done_seen) begin
          done_seen   = 1'b1;
          done_cyc    = cyc;
          seen_lat    = cyc - acc_cyc;
          seen_lsm_en = bus.lsm_en;
          seen_err_m  = bus.err_misaligned;
          seen_err_t  = bus.err_timeout;
          chk("done_latency", seen_lat, cur.lat);
          chk("err_misaligned", bus.err_misaligned, cur.mis);
          chk("err_timeout", bus.err_timeout, cur.to);
          chk("lsm_en", bus.lsm_en, !cur.store && !cur.mis && !cur.to);
          if (bus.lsm_en) begin
            seen_lsm_data = bus.lsm_data;
            chk("lsm_offset", bus.lsm_offset, cur.off);
            chk("lsm_width", bus.lsm_width, cur.width);
            chk("lsm_data", bus.lsm_data, cur.rdata);
          end
        end else if (!bus.done) begin
          chk("flags_without_done", {bus.lsm_en, bus.err_misaligned, bus.err_timeout}, 3'b000);
        end
      end
    end
  end

  // Called aligned at posedge+1; returns aligned at posedge+1 after the done cycle.
  task automatic run_txn(input logic st, input logic [31:0] a, input logic [2:0] w,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int rdy_wait, input int rsp_wait, input logic junk);
    int   reqc, waitc;
    logic in_wait;
    cur = model(st, a, w, wd, rd, rdy_wait, rsp_wait);
    chk("accept_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_addr  = a;
    bus.req_width = w;
    bus.req_wdata = wd;
    acc_cyc   = cyc;
    mreq_cnt  = 0;
    done_seen = 1'b0;
    active    = 1'b1;
    reqc = 0; waitc = 0; in_wait = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = ~a;
    bus.req_wdata = ~wd;
    bus.req_store = ~st;
    for (int t = 0; t < 40; t++) begin
      if (done_seen) break;
      bus.mem_req_ready = bus.mem_req_valid && (reqc >= rdy_wait);
      if (in_wait) begin
        bus.mem_rsp_valid = (waitc == rsp_wait);
        bus.mem_rsp_data  = (waitc == rsp_wait) ? rd : 32'h5A5A_5A5A;
        waitc++;
      end else begin
        bus.mem_rsp_valid = junk;
        bus.mem_rsp_data  = 32'hDEAD_BEEF;
      end
      if (bus.mem_req_valid) reqc++;
      @(negedge clk);
      if (!st && bus.mem_req_valid && bus.mem_req_ready) in_wait = 1'b1;
      @(posedge clk); #1;
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    active = 1'b0;
    chk("done_reached", done_seen, 1'b1);
    chk("mreq_cycles", mreq_cnt, cur.mreq);
  endtask

  exp_t m;
  int   first_done, ndone;

  initial begin
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_addr = 32'd0;
    bus.req_width = 3'd0; bus.req_wdata = 32'd0; bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = 32'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_ctrl_outs", {bus.mem_req_valid, bus.mem_we, bus.lsm_en, bus.done,
                          bus.err_misaligned, bus.err_timeout, bus.busy}, 10'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_lsm_fields", {bus.lsm_offset, bus.lsm_width}, 5'd0);
    chk("rst_lsm_data", bus.lsm_data, 32'd0);

    // Pin the model with hand-computed values.
    m = model(1'b1, 32'h203, 3'b000, 32'h0000_00AB, 32'd0, 0, 0);
    chk("model_sb_we", m.we, 4'b1000);
    chk("model_sb_wdata", m.wdata, 32'hABAB_ABAB);
    chk("model_sb_addr", m.addr, 32'h200);
    chk("model_sb_lat", m.lat, 2);
    m = model(1'b0, 32'h100, 3'b010, 32'd0, 32'h1, 0, 0);
    chk("model_lw_lat", m.lat, 3);
    m = model(1'b0, 32'h101, 3'b001, 32'd0, 32'h1, 0, 0);
    chk("model_lh_mis", {m.mis, 4'(m.lat)}, 5'b1_0001);
    @(posedge clk); #1;

    // Load word, minimum latency.
    run_txn(1'b0, 32'h100, 3'b010, 32'd0, 32'h80FF_1234, 0, 0, 1'b0);
    chk("lw_lat", seen_lat, 3);
    chk("lw_addr", seen_addr, 32'h100);
    chk("lw_we", seen_we, 4'd0);
    chk("lw_lsm_en", seen_lsm_en, 1'b1);
    chk("lw_lsm_data", seen_lsm_data, 32'h80FF_1234);
    // Store byte at offset 3.
    run_txn(1'b1, 32'h203, 3'b000, 32'h0000_00AB, 32'd0, 0, 0, 1'b0);
    chk("sb_lat", seen_lat, 2);
    chk("sb_addr", seen_addr, 32'h200);
    chk("sb_we", seen_we, 4'b1000);
    chk("sb_wdata", seen_wdata, 32'hABAB_ABAB);
    chk("sb_no_lsm", seen_lsm_en, 1'b0);
    // Misaligned requests.
    run_txn(1'b0, 32'h101, 3'b001, 32'd0, 32'd0, 0, 0, 1'b0);
    chk("lh_mis_flags", {seen_err_m, seen_err_t, 4'(seen_lat)}, 6'b10_0001);
    run_txn(1'b0, 32'h102, 3'b011, 32'd0, 32'd0, 0, 0, 1'b0);
    chk("w3_mis_flags", {seen_err_m, seen_err_t, 4'(seen_lat)}, 6'b10_0001);
    run_txn(1'b1, 32'h402, 3'b010, 32'h1234_5678, 32'd0, 0, 0, 1'b0);
    // Other widths and offsets.
    run_txn(1'b1, 32'h302, 3'b001, 32'h1234_CAFE, 32'd0, 0, 0, 1'b0);
    chk("sh_we", seen_we, 4'b1100);
    chk("sh_wdata", seen_wdata, 32'hCAFE_CAFE);
    run_txn(1'b1, 32'h400, 3'b010, 32'hDEAD_BEEF, 32'd0, 0, 0, 1'b0);
    run_txn(1'b0, 32'h503, 3'b100, 32'd0, 32'h0000_00C3, 0, 0, 1'b0);
    // Stalls landing exactly on the last allowed cycle, plus ignored early responses.
    run_txn(1'b0, 32'h504, 3'b010, 32'd0, 32'h1357_9BDF, 1, 1, 1'b0);
    chk("lw_stall_lat", seen_lat, 5);
    run_txn(1'b0, 32'h508, 3'b110, 32'd0, 32'h2468_ACE0, 2, 0, 1'b1);
    chk("junk_rsp_ignored", seen_lsm_data, 32'h2468_ACE0);
    // Timeouts.
    run_txn(1'b1, 32'h600, 3'b010, 32'h0BAD_F00D, 32'd0, 100, 0, 1'b0);
    chk("sw_timeout", {seen_err_m, seen_err_t, 4'(seen_lat), 4'(mreq_cnt)}, 10'b01_0101_0100);
    run_txn(1'b1, 32'h604, 3'b010, 32'h0BAD_F00D, 32'd0, 3, 0, 1'b0);
    chk("sw_last_cycle_hs", {seen_err_m, seen_err_t, 4'(seen_lat)}, 6'b00_0101);
    run_txn(1'b0, 32'h608, 3'b010, 32'd0, 32'h1, 0, 10, 1'b0);
    chk("lw_wait_timeout", {seen_err_t, 4'(seen_lat)}, 5'b1_0101);
    // Back-to-back store then load.
    run_txn(1'b1, 32'h700, 3'b010, 32'hA5A5_0001, 32'd0, 0, 0, 1'b0);
    first_done = done_cyc;
    run_txn(1'b0, 32'h704, 3'b001, 32'd0, 32'hFFFF_8001, 0, 0, 1'b0);
    chk("b2b_accept_cycle", acc_cyc, first_done + 1);

    // Reset while waiting for load data, then a late response.
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_addr = 32'h800; bus.req_width = 3'b010;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    chk("rst_wait_busy", bus.busy, 1'b1);
    rst = 1'b1;
    ndone = 0;
    @(negedge clk); ndone += int'(bus.done);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h1111_2222;
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_ready", bus.req_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ndone += int'(bus.done);
      @(posedge clk); #1;
      bus.mem_rsp_valid = 1'b0;
    end
    chk("rst_no_done", ndone, 0);
    chk("late_rsp_ignored", bus.lsm_data, 32'd0);
    run_txn(1'b0, 32'h900, 3'b010, 32'd0, 32'h7777_0000, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
